// File: rtl/pll_supervisor.sv
// ----------------------------------------------------------------------------
// pll_supervisor
//
// Purpose:
//   Supervises NUM_PLL iCE40 PLL instances from the free-running reference
//   clock. For each channel it pulses the PLL reset and waits for lock. It
//   qualifies lock by requiring it to stay high for a stable window. It
//   retries after lock timeouts or after a loss of lock during hold-off. It
//   releases the downstream domain reset only after a final hold period.
//   Channels are fully independent.
//
// Ports (top):
//   clock_in       in   1          free-running reference clock
//   reset          in   1          synchronous, active-high
//   pll_locked     in   NUM_PLL    raw PLL LOCK outputs (asynchronous)
//   retry_req      in   NUM_PLL    one-cycle pulse, restarts a channel from FAIL
//   pll_resetb     out  NUM_PLL    PLL RESETB, active-low, registered
//   domain_rst     out  NUM_PLL    downstream domain reset, active-high, registered
//   ready          out  NUM_PLL    channel is in RUN, registered
//   failed         out  NUM_PLL    channel is in FAIL, registered
//   lock_loss_cnt  out  8*NUM_PLL  per-channel saturating RUN lock-loss counters
//                                  (channel i on bits [8i+7:8i])
//
// Optional feature:
//   Define PLL_SUPERVISOR_LOSS_CNT_EN to add the lock_loss_cnt port and its
//   counters. When the macro is undefined, the port and the counters are absent.
// ----------------------------------------------------------------------------

// One supervised channel: lock synchroniser, sequencing FSM and output registers.
module pll_supervisor_ch #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 1024,
    parameter int RST_HOLD     = 64,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       retry_req_i,
    output logic       pll_resetb_o,
    output logic       domain_rst_o,
    output logic       ready_o,
    output logic       failed_o
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt_o
`endif
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(RST_PULSE, LOCK_TIMEOUT), max2(LOCK_STABLE, RST_HOLD));
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int RW      = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD - 1);
    localparam logic [RW-1:0] RETRY_ZERO   = RW'(0);
    localparam logic [RW-1:0] RETRY_ONE    = RW'(1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAIL      = 3'd5;

    logic          lock_meta_q;
    logic          lock_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [RW-1:0] retry_inc_s;
    logic          pll_resetb_q;
    logic          domain_rst_q;
    logic          ready_q;
    logic          failed_q;

    // Two-flop synchroniser for the asynchronous PLL lock signal.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, cycle counter and retry bookkeeping.
    // Every state is entered with the counter at zero and leaves on the edge
    // where the counter reads N-1. A lock drop beats a coincident expiry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        retry_inc_s = retry_q + RETRY_ONE;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc_s;
                    cnt_d   = CNT_ZERO;
                    if (retry_inc_s == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                // A drop while qualifying counts as a glitch, not as a failed attempt.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!lock_s_q) begin
                    retry_d = retry_inc_s;
                    cnt_d   = CNT_ZERO;
                    if (retry_inc_s == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                    end
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                    retry_d = RETRY_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                // A loss after a successful bring-up starts over without charging a retry.
                cnt_d = CNT_ZERO;
                if (!lock_s_q) begin
                    state_d = ST_PLL_RST;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAIL: begin
                cnt_d = CNT_ZERO;
                if (retry_req_i) begin
                    state_d = ST_PLL_RST;
                    retry_d = RETRY_ZERO;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = CNT_ZERO;
                retry_d = RETRY_ZERO;
            end
        endcase
    end

    // State registers and outputs decoded from the next state, so that outputs
    // move on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= CNT_ZERO;
            retry_q      <= RETRY_ZERO;
            pll_resetb_q <= 1'b0;
            domain_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            failed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_resetb_q <= (state_d != ST_PLL_RST) && (state_d != ST_FAIL);
            domain_rst_q <= (state_d != ST_RUN);
            ready_q      <= (state_d == ST_RUN);
            failed_q     <= (state_d == ST_FAIL);
        end
    end

    assign pll_resetb_o = pll_resetb_q;
    assign domain_rst_o = domain_rst_q;
    assign ready_o      = ready_q;
    assign failed_o     = failed_q;

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Saturating count of RUN -> PLL_RST transitions.
    always_comb begin
        if ((state_q == ST_RUN) && (state_d == ST_PLL_RST) && (loss_cnt_q != 8'd255)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Loss counter register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule

// Top level: one independent supervisor channel per PLL.
module pll_supervisor #(
    parameter int NUM_PLL      = 2,
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 1024,
    parameter int RST_HOLD     = 64,
    parameter int MAX_RETRY    = 3
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [NUM_PLL-1:0]   pll_locked,
    input  logic [NUM_PLL-1:0]   retry_req,
    output logic [NUM_PLL-1:0]   pll_resetb,
    output logic [NUM_PLL-1:0]   domain_rst,
    output logic [NUM_PLL-1:0]   ready,
    output logic [NUM_PLL-1:0]   failed
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    ,
    output logic [8*NUM_PLL-1:0] lock_loss_cnt
`endif
);

    for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
        pll_supervisor_ch #(
            .RST_PULSE    (RST_PULSE),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .LOCK_STABLE  (LOCK_STABLE),
            .RST_HOLD     (RST_HOLD),
            .MAX_RETRY    (MAX_RETRY)
        ) u_ch (
            .clk_i           (clock_in),
            .rst_i           (reset),
            .pll_locked_i    (pll_locked[i]),
            .retry_req_i     (retry_req[i]),
            .pll_resetb_o    (pll_resetb[i]),
            .domain_rst_o    (domain_rst[i]),
            .ready_o         (ready[i]),
            .failed_o        (failed[i])
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
            ,
            .lock_loss_cnt_o (lock_loss_cnt[8*i +: 8])
`endif
        );
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_supervisor
//
// Self-checking bench for pll_supervisor with NUM_PLL=2, RST_PULSE=4,
// LOCK_TIMEOUT=32, LOCK_STABLE=8, RST_HOLD=4, MAX_RETRY=2.
// A table of per-cycle vectors covers reset and a clean bring-up. Directed
// sequences then cover the stable-window glitch, timeout to FAIL with
// retry_req, lock loss in RUN and reset during HOLD. Expected values are
// counted by hand from the cycle timing: lock driven just after edge E
// reaches the FSM at edge E+3.
// ----------------------------------------------------------------------------
module tb_pll_supervisor;

    logic        clock_in = 1'b0;
    logic        reset;
    logic [1:0]  pll_locked;
    logic [1:0]  retry_req;
    logic [1:0]  pll_resetb;
    logic [1:0]  domain_rst;
    logic [1:0]  ready;
    logic [1:0]  failed;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [1:0] lock;
        logic [1:0] rreq;
        logic [1:0] e_resetb;
        logic [1:0] e_drst;
        logic [1:0] e_ready;
        logic [1:0] e_failed;
    } vec_t;

    vec_t vecs[$];

    pll_supervisor #(
        .NUM_PLL      (2),
        .RST_PULSE    (4),
        .LOCK_TIMEOUT (32),
        .LOCK_STABLE  (8),
        .RST_HOLD     (4),
        .MAX_RETRY    (2)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .pll_locked (pll_locked),
        .retry_req  (retry_req),
        .pll_resetb (pll_resetb),
        .domain_rst (domain_rst),
        .ready      (ready),
        .failed     (failed)
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [1:0] lk, input logic [1:0] rq,
                       input logic [1:0] er, input logic [1:0] ed,
                       input logic [1:0] ey, input logic [1:0] ef);
        vec_t v;
        v.rst = rst; v.lock = lk; v.rreq = rq;
        v.e_resetb = er; v.e_drst = ed; v.e_ready = ey; v.e_failed = ef;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pll_locked = 2'b00;
        retry_req  = 2'b00;
        tick(2);
        reset      = 1'b0;
    endtask

    initial begin
        logic saw_low;
        reset      = 1'b1;
        pll_locked = 2'b00;
        retry_req  = 2'b00;

        // ---------------- clean bring-up table ----------------
        // Reset edge, then 3 edges with pll_resetb low, rise at edge P.
        add(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) add(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        add(1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);   // edge P
        add(1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);   // edge P+1
        // lock[0] raised after P+1: edges P+2..P+15 still held in reset
        for (int k = 0; k < 14; k++) add(1'b0, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
        add(1'b0, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00);   // edge P+16: RUN
        // retry_req outside FAIL is ignored on both channels
        add(1'b0, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00);
        add(1'b0, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            pll_locked = vecs[i].lock;
            retry_req  = vecs[i].rreq;
            tick(1);
            chk($sformatf("vec%0d.pll_resetb", i), 16'(pll_resetb), 16'(vecs[i].e_resetb));
            chk($sformatf("vec%0d.domain_rst", i), 16'(domain_rst), 16'(vecs[i].e_drst));
            chk($sformatf("vec%0d.ready", i),      16'(ready),      16'(vecs[i].e_ready));
            chk($sformatf("vec%0d.failed", i),     16'(failed),     16'(vecs[i].e_failed));
        end
        retry_req = 2'b00;

        // ---------------- stable-window glitch ----------------
        do_reset();
        tick(4);
        chk("glitch.resetb_up", 16'(pll_resetb[0]), 16'd1);
        pll_locked = 2'b01;
        tick(5);
        pll_locked = 2'b00;
        tick(1);
        pll_locked = 2'b01;
        saw_low = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            if (pll_resetb[0] == 1'b0) saw_low = 1'b1;
            if (k == 14) chk("glitch.ready_early", 16'(ready[0]), 16'd0);
        end
        chk("glitch.ready", 16'(ready[0]), 16'd1);
        chk("glitch.domain_rst", 16'(domain_rst[0]), 16'd0);
        chk("glitch.no_retry_pulse", 16'(saw_low), 16'd0);

        // ---------------- timeout to FAIL, then retry_req ----------------
        do_reset();
        tick(4);                                        // P: WAIT_LOCK
        chk("tmo.resetb_p", 16'(pll_resetb[1]), 16'd1);
        tick(31);
        chk("tmo.resetb_p31", 16'(pll_resetb[1]), 16'd1);
        tick(1);                                        // P+32: first timeout
        chk("tmo.resetb_p32", 16'(pll_resetb[1]), 16'd0);
        chk("tmo.failed_p32", 16'(failed[1]), 16'd0);
        tick(3);
        chk("tmo.resetb_p35", 16'(pll_resetb[1]), 16'd0);
        tick(1);
        chk("tmo.resetb_p36", 16'(pll_resetb[1]), 16'd1);
        tick(31);
        chk("tmo.failed_p67", 16'(failed[1]), 16'd0);
        tick(1);                                        // P+68: second timeout
        chk("tmo.failed_p68", 16'(failed), 16'd3);
        chk("tmo.resetb_p68", 16'(pll_resetb), 16'd0);
        chk("tmo.drst_p68", 16'(domain_rst), 16'd3);
        tick(10);
        chk("tmo.failed_held", 16'(failed), 16'd3);
        chk("tmo.resetb_held", 16'(pll_resetb), 16'd0);
        retry_req = 2'b10;
        tick(1);                                        // edge F: FAIL -> PLL_RST
        retry_req = 2'b00;
        chk("tmo.failed_after_retry", 16'(failed), 16'd1);
        chk("tmo.resetb_f", 16'(pll_resetb[1]), 16'd0);
        tick(3);
        chk("tmo.resetb_f3", 16'(pll_resetb[1]), 16'd0);
        tick(1);
        chk("tmo.resetb_f4", 16'(pll_resetb[1]), 16'd1);
        chk("tmo.ch0_still_failed", 16'(failed[0]), 16'd1);

        // ---------------- lock loss in RUN ----------------
        do_reset();
        tick(4);
        pll_locked = 2'b01;
        tick(14);
        chk("loss.ready_early", 16'(ready[0]), 16'd0);
        tick(1);
        chk("loss.ready", 16'(ready[0]), 16'd1);
        pll_locked = 2'b00;                             // after edge L
        tick(2);
        chk("loss.ready_l2", 16'(ready[0]), 16'd1);
        chk("loss.drst_l2", 16'(domain_rst[0]), 16'd0);
        tick(1);
        chk("loss.drst_l3", 16'(domain_rst[0]), 16'd1);
        chk("loss.ready_l3", 16'(ready[0]), 16'd0);
        chk("loss.resetb_l3", 16'(pll_resetb[0]), 16'd0);
        tick(3);
        chk("loss.resetb_l6", 16'(pll_resetb[0]), 16'd0);
        tick(1);
        chk("loss.resetb_l7", 16'(pll_resetb[0]), 16'd1);
        pll_locked = 2'b01;
        tick(14);
        chk("loss.relock_early", 16'(ready[0]), 16'd0);
        tick(1);
        chk("loss.relock", 16'(ready[0]), 16'd1);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        chk("loss.cnt_one", 16'(lock_loss_cnt), 16'h0001);
        for (int n = 0; n < 299; n++) begin
            pll_locked = 2'b00;
            tick(7);
            pll_locked = 2'b01;
            tick(15);
        end
        chk("loss.cnt_sat", 16'(lock_loss_cnt[7:0]), 16'd255);
        chk("loss.cnt_ch1", 16'(lock_loss_cnt[15:8]), 16'd0);
        chk("loss.ready_after_loop", 16'(ready[0]), 16'd1);
`endif

        // ---------------- reset during HOLD ----------------
        do_reset();
        tick(4);
        pll_locked = 2'b01;
        tick(12);                                       // HOLD (entered one edge earlier)
        chk("hold.drst_in_hold", 16'(domain_rst[0]), 16'd1);
        chk("hold.resetb_in_hold", 16'(pll_resetb[0]), 16'd1);
        reset      = 1'b1;
        pll_locked = 2'b00;
        tick(1);
        chk("hold.rst_resetb", 16'(pll_resetb), 16'd0);
        chk("hold.rst_drst", 16'(domain_rst), 16'd3);
        chk("hold.rst_ready", 16'(ready), 16'd0);
        chk("hold.rst_failed", 16'(failed), 16'd0);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        chk("hold.rst_loss_cnt", 16'(lock_loss_cnt), 16'd0);
`endif
        reset = 1'b0;
        tick(3);
        chk("hold.resetb_a2", 16'(pll_resetb), 16'd0);
        tick(1);
        chk("hold.resetb_a3", 16'(pll_resetb), 16'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
